adder_rr_arbiter: RTL and testbench

//  Shares one 64-bit lookaheadadder instance among NREQ requesters using round-robin arbitration.
//  - Each requester uses a valid/ready operand handshake.
//  - Operands and the result are registered; the adder gets one full cycle to settle.
//  - Results return on a single valid/ready response channel, tagged with the requester ID.
//  - The block sits between the execution clients and the shared adder datapath.

---
 rtl/adder_rr_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_adder_rr_arbiter.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/adder_rr_arbiter.sv
// adder_rr_arbiter: round-robin front end for one shared 64-bit carry-lookahead adder.
// Requesters present operands over valid/ready. The granted operands are registered, the
// adder settles for a full cycle, and the registered sum is returned on one response
// channel tagged with the requester ID. One operation takes three cycles: IDLE, ADD, HOLD.
// Optional feature: define ADDER_ARB_STATS_EN to add the STAT_COUNT port and a
// saturating completion counter.
module adder_rr_arbiter #(
    parameter int NREQ = 4,
    localparam int IDW = $clog2(NREQ)
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [NREQ-1:0]      REQ_VALID,
    output logic [NREQ-1:0]      REQ_READY,
    input  logic [NREQ*64-1:0]   REQ_A,
    input  logic [NREQ*64-1:0]   REQ_B,
    output logic                 RSP_VALID,
    input  logic                 RSP_READY,
    output logic [63:0]          RSP_SUM,
    output logic [IDW-1:0]       RSP_ID
`ifdef ADDER_ARB_STATS_EN
    ,
    output logic [31:0]          STAT_COUNT
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t         state_reg;
    state_t         state_next;

    logic [IDW-1:0] ptr_reg;
    logic [IDW-1:0] ptr_next;
    logic [63:0]    op_a_reg;
    logic [63:0]    op_b_reg;
    logic [IDW-1:0] id_reg;
    logic [63:0]    sum_reg;

    logic           grant_valid;
    logic [IDW-1:0] grant_idx;
    logic           accept;
    logic           rsp_fire;
    logic [63:0]    adder_sum;

    // Round-robin search: first valid requester at or after ptr_reg, wrapping to 0.
    // Scanning from the farthest offset back towards ptr_reg lets the nearest one win.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            int s;
            s = int'(ptr_reg) + k;
            if (s >= NREQ) begin
                s = s - NREQ;
            end
            if (REQ_VALID[s]) begin
                grant_valid = 1'b1;
                grant_idx   = IDW'(s);
            end
        end
    end

    // Pointer moves to the slot just past the winner, wrapping at NREQ-1.
    always_comb begin
        ptr_next = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + IDW'(1);
    end

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (grant_valid) state_next = ADD;
            ADD:     state_next = HOLD;
            HOLD:    if (RSP_READY) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs: the one-hot ready is gated by reset so nothing is accepted while RST is high.
    always_comb begin
        accept    = (state_reg == IDLE) && grant_valid && !RST;
        RSP_VALID = (state_reg == HOLD) && !RST;
        rsp_fire  = RSP_VALID && RSP_READY;
        REQ_READY = '0;
        if (accept) begin
            REQ_READY[grant_idx] = 1'b1;
        end
    end

    // Datapath: capture operands and ID on accept, capture the adder result at the end of ADD.
    always_ff @(posedge CLK) begin
        if (RST) begin
            ptr_reg  <= '0;
            op_a_reg <= '0;
            op_b_reg <= '0;
            id_reg   <= '0;
            sum_reg  <= '0;
        end else begin
            if (accept) begin
                ptr_reg  <= ptr_next;
                op_a_reg <= REQ_A[int'(grant_idx) * 64 +: 64];
                op_b_reg <= REQ_B[int'(grant_idx) * 64 +: 64];
                id_reg   <= grant_idx;
            end
            if (state_reg == ADD) begin
                sum_reg <= adder_sum;
            end
        end
    end

    assign RSP_SUM = sum_reg;
    assign RSP_ID  = id_reg;

    // Carry-lookahead adder: 4-bit lookahead groups, group generate/propagate chained
    // between groups. Carry-in is 0 and the final carry-out is not formed.
    logic [63:0] gen_bit;
    logic [63:0] prop_bit;
    logic [63:0] carry;

    assign gen_bit  = op_a_reg & op_b_reg;
    assign prop_bit = op_a_reg ^ op_b_reg;
    assign carry[0] = 1'b0;

    for (genvar gi = 0; gi < 16; gi++) begin : g_cla
        localparam int B = 4 * gi;
        logic [3:0] g;
        logic [3:0] p;
        logic       cin;

        assign g   = gen_bit[B +: 4];
        assign p   = prop_bit[B +: 4];
        assign cin = carry[B];

        assign carry[B+1] = g[0] | (p[0] & cin);
        assign carry[B+2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        assign carry[B+3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                          | (p[2] & p[1] & p[0] & cin);

        if (gi < 15) begin : g_link
            logic grp_g;
            logic grp_p;
            assign grp_g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                         | (p[3] & p[2] & p[1] & g[0]);
            assign grp_p = &p;
            assign carry[B+4] = grp_g | (grp_p & cin);
        end
    end

    assign adder_sum = prop_bit ^ carry;

`ifdef ADDER_ARB_STATS_EN
    logic [31:0] stat_count_reg;

    // Completed-operation counter; saturates instead of wrapping.
    always_ff @(posedge CLK) begin
        if (RST) begin
            stat_count_reg <= '0;
        end else if (rsp_fire && (stat_count_reg != 32'hFFFF_FFFF)) begin
            stat_count_reg <= stat_count_reg + 32'd1;
        end
    end

    assign STAT_COUNT = stat_count_reg;
`else
    // Without the counter the handshake fire signal has no consumer.
    logic unused_fire;
    assign unused_fire = rsp_fire;
`endif

endmodule

// File: tb/tb_adder_rr_arbiter.sv
// Directed testbench for adder_rr_arbiter (NREQ = 4): reset, single request, round-robin
// rotation, backpressure with overflow, reset during ADD and, with ADDER_ARB_STATS_EN, the
// completion counter.
module tb_adder_rr_arbiter;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic                 CLK = 1'b0;
    logic                 RST;
    logic [NREQ-1:0]      REQ_VALID;
    logic [NREQ-1:0]      REQ_READY;
    logic [NREQ*64-1:0]   REQ_A;
    logic [NREQ*64-1:0]   REQ_B;
    logic                 RSP_VALID;
    logic                 RSP_READY;
    logic [63:0]          RSP_SUM;
    logic [IDW-1:0]       RSP_ID;
`ifdef ADDER_ARB_STATS_EN
    logic [31:0]          STAT_COUNT;
`endif

    int checks = 0;
    int errors = 0;

    adder_rr_arbiter #(.NREQ(NREQ)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .REQ_VALID (REQ_VALID),
        .REQ_READY (REQ_READY),
        .REQ_A     (REQ_A),
        .REQ_B     (REQ_B),
        .RSP_VALID (RSP_VALID),
        .RSP_READY (RSP_READY),
        .RSP_SUM   (RSP_SUM),
        .RSP_ID    (RSP_ID)
`ifdef ADDER_ARB_STATS_EN
        ,
        .STAT_COUNT(STAT_COUNT)
`endif
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_ops(input int i, input logic [63:0] a, input logic [63:0] b);
        REQ_A[64*i +: 64] = a;
        REQ_B[64*i +: 64] = b;
    endtask

    // One full operation starting in IDLE with the winner already valid and RSP_READY=1.
    task automatic do_op(input string tag, input int exp_id, input logic [63:0] exp_sum);
        logic [3:0] onehot;
        onehot = 4'b0001 << exp_id;
        chk({tag, "_ready"}, 64'(REQ_READY), 64'(onehot));
        step();
        chk({tag, "_add_valid"}, 64'(RSP_VALID), 64'd0);
        chk({tag, "_add_ready"}, 64'(REQ_READY), 64'd0);
        step();
        chk({tag, "_valid"}, 64'(RSP_VALID), 64'd1);
        chk({tag, "_id"}, 64'(RSP_ID), 64'(exp_id));
        chk({tag, "_sum"}, RSP_SUM, exp_sum);
        $display("op %s id=%0d sum=0x%0h", tag, RSP_ID, RSP_SUM);
        step();
    endtask

    initial begin
        RST       = 1'b1;
        REQ_VALID = 4'hF;
        REQ_A     = '0;
        REQ_B     = '0;
        RSP_READY = 1'b0;

        // 1: reset held 3 cycles with every requester valid
        for (int c = 0; c < 3; c++) begin
            step();
            chk("rst_ready", 64'(REQ_READY), 64'd0);
            chk("rst_valid", 64'(RSP_VALID), 64'd0);
            chk("rst_sum", RSP_SUM, 64'd0);
            chk("rst_id", 64'(RSP_ID), 64'd0);
        end
        RST       = 1'b0;
        REQ_VALID = 4'h0;
        step();
        chk("idle_valid", 64'(RSP_VALID), 64'd0);

        // 2: single request from requester 2, carry across bit 32
        set_ops(2, 64'h0000_0000_FFFF_FFFF, 64'd1);
        REQ_VALID = 4'b0100;
        RSP_READY = 1'b1;
        #1;
        chk("single_ready", 64'(REQ_READY), 64'h4);
        step();
        REQ_VALID = 4'b0000;
        chk("single_add_valid", 64'(RSP_VALID), 64'd0);
        step();
        chk("single_valid", 64'(RSP_VALID), 64'd1);
        chk("single_sum", RSP_SUM, 64'h0000_0001_0000_0000);
        chk("single_id", 64'(RSP_ID), 64'd2);
        $display("op single id=%0d sum=0x%0h", RSP_ID, RSP_SUM);
        step();

        // re-align the pointer to 0 before the rotation test
        RST = 1'b1;
        step();
        RST = 1'b0;

        // 3: all requesters valid -> grants 0,1,2,3,0, one result every 3 cycles
        for (int i = 0; i < NREQ; i++) begin
            set_ops(i, 64'(i), 64'h10);
        end
        REQ_VALID = 4'hF;
        #1;
        for (int n = 0; n < 5; n++) begin
            do_op($sformatf("rr%0d", n), n % NREQ, 64'h10 + 64'(n % NREQ));
        end

        // 4: backpressure; pointer is now 1, requester 1 adds 2^63 + 2^63 = 0 (wrap)
        REQ_VALID = 4'b0010;
        RSP_READY = 1'b0;
        set_ops(1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000);
        #1;
        chk("bp_ready", 64'(REQ_READY), 64'h2);
        step();
        REQ_VALID = 4'hF;
        step();
        for (int c = 0; c < 5; c++) begin
            chk("bp_valid", 64'(RSP_VALID), 64'd1);
            chk("bp_sum", RSP_SUM, 64'd0);
            chk("bp_id", 64'(RSP_ID), 64'd1);
            chk("bp_req_ready", 64'(REQ_READY), 64'd0);
            step();
        end
        RSP_READY = 1'b1;
        #1;
        chk("bp_release_valid", 64'(RSP_VALID), 64'd1);
        $display("op backpressure id=%0d sum=0x%0h", RSP_ID, RSP_SUM);
        REQ_VALID = 4'h0;
        step();
        chk("bp_done_valid", 64'(RSP_VALID), 64'd0);

        // 5: reset during ADD drops the operation; pointer returns to 0
        REQ_VALID = 4'b0010;
        #1;
        chk("mid_ready", 64'(REQ_READY), 64'h2);
        step();
        REQ_VALID = 4'h0;
        RST       = 1'b1;
        #1;
        chk("mid_rst_ready", 64'(REQ_READY), 64'd0);
        step();
        RST = 1'b0;
        for (int c = 0; c < 4; c++) begin
            chk("mid_no_rsp", 64'(RSP_VALID), 64'd0);
            step();
        end
        REQ_VALID = 4'hF;
        #1;
        do_op("after_rst", 0, 64'h10);
        REQ_VALID = 4'h0;

`ifdef ADDER_ARB_STATS_EN
        // 6: completion counter and saturation
        RST = 1'b1;
        step();
        RST = 1'b0;
        chk("stat_reset", 64'(STAT_COUNT), 64'd0);
        REQ_VALID = 4'hF;
        #1;
        for (int n = 0; n < 7; n++) begin
            do_op($sformatf("stat%0d", n), n % NREQ, 64'h10 + 64'(n % NREQ));
        end
        chk("stat_seven", 64'(STAT_COUNT), 64'd7);
        dut.stat_count_reg = 32'hFFFF_FFFF;
        #1;
        do_op("stat_sat", 3, 64'h13);
        chk("stat_saturate", 64'(STAT_COUNT), 64'hFFFF_FFFF);
        REQ_VALID = 4'h0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
